lcd_driver: RTL
===============

# lcd_driver

Drives the 128x64 two-controller graphic LCD panel from the column-byte stream that the frame RAM controller produces. After reset it runs the panel power-up sequence. It then pulls bytes from the upstream `data_out`/`data_valid` port with a request pulse on `en`, and writes each byte to the panel as one bus cycle: 64 columns per page, 8 pages per frame, looping forever. It sits between the RAM controller and the board LCD pins.

## Interface
Parameters:
- DIV, 4: clk cycles per bus-cycle phase (setup, E-high, hold); must be >= 1
- RST_CYCLES, 16: clk cycles `lcd_rst_n` is held low after reset
- HALF, 0: panel half written; 0 selects CS1 (left), 1 selects CS2 (right)
- RETRY, 3: clk cycles to wait for `data_valid` before re-pulsing `en`

Ports:
- clk, input, 1: system clock
- rst_n, input, 1: reset, asynchronous, active-low
- data_in, input, 8: column byte from upstream; bit 0 is the top pixel of the page
- data_valid, input, 1: `data_in` is valid this cycle (one-cycle pulse)
- en, output, 1: one-cycle request for the next byte
- lcd_rst_n, output, 1: panel reset, active-low
- lcd_cs1, output, 1: chip select, left half
- lcd_cs2, output, 1: chip select, right half
- lcd_di, output, 1: 0 = instruction, 1 = display data
- lcd_rw, output, 1: tied 0 (write only)
- lcd_e, output, 1: enable strobe
- lcd_data, output, 8: panel data bus
- frame_done, output, 1: one-cycle pulse after the last byte of page 7 is written

## Operation
- Reset values: en=0, lcd_rst_n=0, lcd_cs1=0, lcd_cs2=0, lcd_di=0, lcd_rw=0, lcd_e=0, lcd_data=8'h00, frame_done=0. Page=0, column=0.
- FSM states:
  - RST_HOLD: count RST_CYCLES, then lcd_rst_n=1 and go to INIT_ON.
  - INIT_ON: instruction 8'h3F (display on).
  - INIT_LINE: instruction 8'hC0 (start line 0).
  - SET_PAGE: instruction 8'hB8 | page.
  - SET_Y: instruction 8'h40 (column 0).
  - REQ: pulse en for 1 cycle.
  - WAIT: wait for data_valid.
  - WRITE: data write of the latched byte.
- Transitions:
  - Each instruction state advances when its bus cycle completes.
  - SET_Y → REQ.
  - WAIT → WRITE on data_valid. If RETRY cycles pass with no data_valid, go back to REQ. Upstream ignores `en` while it refills, so retries are expected and harmless.
  - WRITE complete: column+1. If the column wraps from 63 to 0, page+1 mod 8 and go to SET_PAGE. Otherwise go to REQ.
  - frame_done pulses when page wraps 7→0.
- data_valid outside WAIT is ignored and does not alter state.
- data_in is latched into an 8-bit register on the data_valid cycle. lcd_data is driven from that register for the whole bus cycle.
- The selected CS is high from RST_HOLD exit onward. The other CS stays 0.
- Column and page counters are 6 and 3 bits and wrap naturally. Never re-init after the first frame.

## Timing
- Bus cycle is 3*DIV clks:
  - Setup: DIV clks. lcd_di and lcd_data are valid, lcd_e=0.
  - Strobe: DIV clks with lcd_e=1.
  - Hold: DIV clks with lcd_e=0, lcd_di and lcd_data held.
  - `done` asserts in the last hold clk.
- lcd_di and lcd_data change only in the first setup clk.
- en rises the clk after entering REQ and is high for exactly 1 clk. Upstream returns data_valid 1 clk after sampling en. WAIT therefore sees data_valid in the clk after the en pulse when upstream is streaming.
- Steady-state byte period: 1 (REQ) + 1 (WAIT) + 3*DIV. DIV=4 gives 14 clks/byte.
- Page overhead: 2 instruction cycles, 6*DIV clks.
- Reset mid-operation: all outputs return to reset values asynchronously, and the full init sequence reruns. Upstream shares rst_n, so page alignment is restored.

## Structure
- Shared package `lcd_pkg` holds:
  - Instruction constants: CMD_DISP_ON=8'h3F, CMD_START_LINE=8'hC0, CMD_PAGE=8'hB8, CMD_COL=8'h40.
  - The FSM state encoding.
  - PAGES=8, COLS=64.
- One sub-module, `lcd_bus_cycle`:
  - Inputs: start, di, byte.
  - Outputs: lcd_e, lcd_di, lcd_data, done.
  - Parameter: DIV.
  - Owns the phase counter and ignores start while busy.

## Test plan
- Reset release, RST_CYCLES=16 → lcd_rst_n rises at clk 16. Next, bus cycles carry 3F (di=0), C0, B8, 40, then en pulses once.
- Upstream model answers each en with data_valid one clk later, data=col index → 64 writes with di=1, lcd_data=0..63. Then instruction B9, then 40.
- Upstream silent for 10 clks (refill) with RETRY=3 → en re-pulses every 4 clks. The first data_valid produces exactly one write, and the column does not skip.
- Stream 512 bytes → page sequence B8..BF, frame_done pulses once after byte 511, next instruction B8. No second init.
- Spurious data_valid during a WRITE bus cycle → ignored; lcd_data unchanged through the hold phase.
- rst_n asserted mid-page (column 30) → outputs reset immediately. After release, the init sequence repeats and writes restart at page 0, column 0. HALF=1 → only lcd_cs2 high.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - panel instruction codes, geometry and FSM encoding for lcd_driver
package lcd_pkg;

  localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
  localparam logic [7:0] CMD_START_LINE = 8'hC0;
  localparam logic [7:0] CMD_PAGE       = 8'hB8;
  localparam logic [7:0] CMD_COL        = 8'h40;

  localparam int PAGES = 8;
  localparam int COLS  = 64;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_INIT_ON,
    ST_INIT_LINE,
    ST_SET_PAGE,
    ST_SET_Y,
    ST_REQ,
    ST_WAIT,
    ST_WRITE
  } lcd_state_t;

  function automatic logic [7:0] page_cmd(input logic [2:0] page);
    return CMD_PAGE | {5'b0, page};
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// rtl/lcd_bus_cycle.sv - one panel write cycle: setup, E strobe, hold, each DIV clks
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       di,
  input  logic [7:0] data_byte,
  output logic       lcd_e,
  output logic       lcd_di,
  output logic [7:0] lcd_data,
  output logic       done
);

  localparam int CW = $clog2(3 * DIV);
  localparam logic [CW-1:0] E_ON  = CW'(DIV);
  localparam logic [CW-1:0] E_OFF = CW'(2 * DIV);
  localparam logic [CW-1:0] LAST  = CW'(3 * DIV - 1);

  logic          busy;
  logic [CW-1:0] phase;
  logic [CW-1:0] phase_nxt;
  logic          accept;

  assign phase_nxt = phase + 1'b1;
  // The last hold clk may chain straight into the next cycle, so back-to-back
  // cycles have no idle gap; any other start while busy is dropped.
  assign accept = start && (!busy || done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      phase    <= '0;
      lcd_e    <= 1'b0;
      lcd_di   <= 1'b0;
      lcd_data <= 8'h00;
      done     <= 1'b0;
    end else if (accept) begin
      busy     <= 1'b1;
      phase    <= '0;
      lcd_e    <= 1'b0;
      lcd_di   <= di;
      lcd_data <= data_byte;
      done     <= 1'b0;
    end else if (busy) begin
      if (phase == LAST) begin
        busy  <= 1'b0;
        lcd_e <= 1'b0;
        done  <= 1'b0;
      end else begin
        phase <= phase_nxt;
        lcd_e <= (phase_nxt >= E_ON) && (phase_nxt < E_OFF);
        done  <= (phase_nxt == LAST);
      end
    end
  end

endmodule

// File: rtl/lcd_driver.sv
// rtl/lcd_driver.sv - power-up sequence then endless page/column refresh of one panel half
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int RST_CYCLES = 16,
  parameter int HALF       = 0,
  parameter int RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       en,
  output logic       lcd_rst_n,
  output logic       lcd_cs1,
  output logic       lcd_cs2,
  output logic       lcd_di,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       frame_done
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(RETRY + 1);
  localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] RETRY_LAST = TW'(RETRY - 1);

  lcd_state_t    state;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] retry_cnt;
  logic [2:0]    page;
  logic [5:0]    col;
  logic          col_last;

  logic          bus_start;
  logic          bus_di;
  logic [7:0]    bus_byte;
  logic          bus_done;

  assign lcd_rw   = 1'b0;
  assign col_last = (col == 6'(COLS - 1));

  // Each bus cycle is launched on the same edge that enters the state owning it,
  // so instruction states cost exactly one bus cycle and data writes chain with no gap.
  always_comb begin
    bus_start = 1'b0;
    bus_di    = 1'b0;
    bus_byte  = 8'h00;
    case (state)
      ST_RST_HOLD: begin
        bus_start = (rst_cnt == RST_LAST);
        bus_byte  = CMD_DISP_ON;
      end
      ST_INIT_ON: begin
        bus_start = bus_done;
        bus_byte  = CMD_START_LINE;
      end
      ST_INIT_LINE: begin
        bus_start = bus_done;
        bus_byte  = page_cmd(page);
      end
      ST_SET_PAGE: begin
        bus_start = bus_done;
        bus_byte  = CMD_COL;
      end
      ST_WAIT: begin
        bus_start = data_valid;
        bus_di    = 1'b1;
        bus_byte  = data_in;
      end
      ST_WRITE: begin
        bus_start = bus_done && col_last;
        bus_byte  = page_cmd(page + 3'd1);
      end
      default: begin
        bus_start = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RST_HOLD;
      rst_cnt    <= '0;
      retry_cnt  <= '0;
      page       <= 3'd0;
      col        <= 6'd0;
      en         <= 1'b0;
      lcd_rst_n  <= 1'b0;
      lcd_cs1    <= 1'b0;
      lcd_cs2    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      en         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_RST_HOLD: begin
          if (rst_cnt == RST_LAST) begin
            lcd_rst_n <= 1'b1;
            lcd_cs1   <= (HALF == 0);
            lcd_cs2   <= (HALF != 0);
            state     <= ST_INIT_ON;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_INIT_ON:   if (bus_done) state <= ST_INIT_LINE;
        ST_INIT_LINE: if (bus_done) state <= ST_SET_PAGE;
        ST_SET_PAGE:  if (bus_done) state <= ST_SET_Y;
        ST_SET_Y: begin
          if (bus_done) begin
            state <= ST_REQ;
            en    <= 1'b1;
          end
        end
        ST_REQ: begin
          state     <= ST_WAIT;
          retry_cnt <= '0;
        end
        ST_WAIT: begin
          if (data_valid) begin
            state <= ST_WRITE;
          end else if (retry_cnt == RETRY_LAST) begin
            state <= ST_REQ;
            en    <= 1'b1;
          end else begin
            retry_cnt <= retry_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          if (bus_done) begin
            col <= col + 1'b1;
            if (col_last) begin
              page  <= page + 3'd1;
              state <= ST_SET_PAGE;
              if (page == 3'(PAGES - 1)) frame_done <= 1'b1;
            end else begin
              state <= ST_REQ;
              en    <= 1'b1;
            end
          end
        end
        default: state <= ST_RST_HOLD;
      endcase
    end
  end

  lcd_bus_cycle #(
    .DIV(DIV)
  ) u_bus (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (bus_start),
    .di       (bus_di),
    .data_byte(bus_byte),
    .lcd_e    (lcd_e),
    .lcd_di   (lcd_di),
    .lcd_data (lcd_data),
    .done     (bus_done)
  );

endmodule
